lif_network_p: RTL and testbench



---
 rtl/lif_pkg.sv | 25 ++
 rtl/lif_neuron_p.sv | 75 +++++++
 rtl/lif_network_p.sv | 83 ++++++++
 tb/tb_lif_network_p.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants, typedefs and saturating arithmetic helpers for the LIF network.
package lif_pkg;

  localparam int DEF_W          = 8;
  localparam int DEF_WEIGHT_W   = 4;
  localparam int DEF_THRESHOLD  = 128;
  localparam int DEF_LEAK_SHIFT = 2;

  typedef logic [DEF_W-1:0]               membrane_t;
  typedef logic signed [DEF_WEIGHT_W-1:0] weight_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] maxVal);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, maxVal}) ? maxVal : s[31:0];
  endfunction

  function automatic logic [31:0] clamp_u(input int s, input int maxVal);
    if (s < 0)           return 32'd0;
    else if (s > maxVal) return maxVal;
    else                 return s;
  endfunction

endpackage

// File: rtl/lif_neuron_p.sv
// Single leaky integrate-and-fire neuron with saturating input and reset-to-zero on spike.
// Optional refractory counter enabled by LIF_NETWORK_REFRACTORY_EN.
module lif_neuron_p
  import lif_pkg::*;
#(
  parameter int W              = DEF_W,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] current_i,
  output logic         spike_o,
  output logic [W-1:0] state_o
);

  localparam logic [31:0] MaxV = 32'((64'd1 << W) - 64'd1);

  logic [W-1:0] state_q, state_d, leaked;
  logic         spike_q, spike_d;
  logic [31:0]  vWide;
  logic         unused_vHi;

  always_comb begin
    leaked  = state_q - (state_q >> LEAK_SHIFT);
    vWide   = sat_add(32'(leaked), 32'(current_i), MaxV);
    spike_d = (vWide >= 32'(THRESHOLD));
    state_d = spike_d ? '0 : vWide[W-1:0];
  end

  assign unused_vHi = |vWide[31:W];

`ifdef LIF_NETWORK_REFRACTORY_EN
  localparam int CW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  logic [CW-1:0] refrCnt_q;

  // A nonzero counter clamps the neuron silent and drains once per enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      spike_q   <= 1'b0;
      refrCnt_q <= '0;
    end else if (ena) begin
      if (refrCnt_q != '0) begin
        state_q   <= '0;
        spike_q   <= 1'b0;
        refrCnt_q <= refrCnt_q - 1'b1;
      end else begin
        state_q   <= state_d;
        spike_q   <= spike_d;
        refrCnt_q <= spike_d ? CW'(REFRACT_CYCLES) : '0;
      end
    end
  end
`else
  logic unused_refract;
  assign unused_refract = ^32'(REFRACT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      spike_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      spike_q <= spike_d;
    end
  end
`endif

  assign spike_o = spike_q;
  assign state_o = state_q;

endmodule

// File: rtl/lif_network_p.sv
// N_IN-input LIF network: input neurons -> weighted clamped sum -> output neuron (3-stage pipeline).
// Refractory behaviour of all neurons selected by LIF_NETWORK_REFRACTORY_EN.
module lif_network_p
  import lif_pkg::*;
#(
  parameter int N_IN           = 8,
  parameter int W              = DEF_W,
  parameter int WEIGHT_W       = DEF_WEIGHT_W,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [N_IN*W-1:0]          current,
  input  logic                       w_wr_en,
  input  logic [$clog2(N_IN)-1:0]    w_wr_addr,
  input  logic signed [WEIGHT_W-1:0] w_wr_data,
  output logic [N_IN-1:0]            l1_spikes,
  output logic [W-1:0]               sum_out,
  output logic                       spike_out,
  output logic [W-1:0]               state_out
);

  localparam int SW   = $clog2(N_IN) + WEIGHT_W + 1;
  localparam int MaxV = (1 << W) - 1;

  logic signed [WEIGHT_W-1:0] weight_q [N_IN];
  logic signed [SW-1:0]       sumS;
  logic [31:0]                sumClamp;
  logic [W-1:0]               sum_q, sum_d;
  logic [W-1:0]               unused_l1State [N_IN];
  logic                       unused_sumHi;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    lif_neuron_p #(
      .W(W), .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT), .REFRACT_CYCLES(REFRACT_CYCLES)
    ) u_neuron (
      .clk(clk), .rst(rst), .ena(ena),
      .current_i(current[i*W +: W]),
      .spike_o(l1_spikes[i]),
      .state_o(unused_l1State[i])
    );
  end

  // Weight writes ignore ena; reset restores the unit-weight network and drops any coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= WEIGHT_W'(1);
    end else if (w_wr_en && (32'(w_wr_addr) < 32'(N_IN))) begin
      weight_q[w_wr_addr] <= w_wr_data;
    end
  end

  always_comb begin
    sumS = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (l1_spikes[i]) sumS = sumS + {{(SW-WEIGHT_W){weight_q[i][WEIGHT_W-1]}}, weight_q[i]};
    end
    sumClamp = clamp_u(int'(sumS), MaxV);
    sum_d    = sumClamp[W-1:0];
  end

  assign unused_sumHi = |sumClamp[31:W];

  always_ff @(posedge clk) begin
    if (rst)      sum_q <= '0;
    else if (ena) sum_q <= sum_d;
  end

  lif_neuron_p #(
    .W(W), .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT), .REFRACT_CYCLES(REFRACT_CYCLES)
  ) u_out (
    .clk(clk), .rst(rst), .ena(ena),
    .current_i(sum_q),
    .spike_o(spike_out),
    .state_o(state_out)
  );

  assign sum_out = sum_q;

endmodule

// File: tb/tb_lif_network_p.sv
// Randomised and directed bench for lif_network_p against an arithmetic network model.
module tb_lif_network_p;

  localparam int N    = 8;
  localparam int W    = 8;
  localparam int WW   = 4;
  localparam int TH   = 128;
  localparam int LS   = 2;
  localparam int RC   = 2;
  localparam int AW   = $clog2(N);
  localparam int MAXV = (1 << W) - 1;

  logic                 clk = 1'b0;
  logic                 rst, ena, w_wr_en;
  logic [N*W-1:0]       current;
  logic [AW-1:0]        w_wr_addr;
  logic signed [WW-1:0] w_wr_data;
  logic [N-1:0]         l1_spikes;
  logic [W-1:0]         sum_out, state_out;
  logic                 spike_out;

  int testsRun  = 0;
  int failCount = 0;

  // Index N of the neuron arrays is the output neuron.
  int mState [N+1];
  int mSpike [N+1];
  int mRefr  [N+1];
  int mWeight[N];
  int mSum;
  int curVal [N];

  always #5 clk = ~clk;

  lif_network_p #(
    .N_IN(N), .W(W), .WEIGHT_W(WW), .THRESHOLD(TH), .LEAK_SHIFT(LS), .REFRACT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .current(current),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .l1_spikes(l1_spikes), .sum_out(sum_out), .spike_out(spike_out), .state_out(state_out)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic void neuronStep(input int idx, input int inCur);
    int v;
`ifdef LIF_NETWORK_REFRACTORY_EN
    if (mRefr[idx] > 0) begin
      mRefr[idx]--;
      mState[idx] = 0;
      mSpike[idx] = 0;
      return;
    end
`endif
    v = mState[idx] - (mState[idx] / (1 << LS)) + inCur;
    if (v > MAXV) v = MAXV;
    mSpike[idx] = (v >= TH) ? 1 : 0;
    mState[idx] = mSpike[idx] ? 0 : v;
    mRefr[idx]  = mSpike[idx] ? RC : 0;
  endfunction

  function automatic void modelEdge(input bit r, input bit e, input bit we, input int wa, input int wd);
    int s;
    if (r) begin
      for (int i = 0; i <= N; i++) begin
        mState[i] = 0; mSpike[i] = 0; mRefr[i] = 0;
      end
      for (int i = 0; i < N; i++) mWeight[i] = 1;
      mSum = 0;
      return;
    end
    if (e) begin
      neuronStep(N, mSum);
      s = 0;
      for (int i = 0; i < N; i++) if (mSpike[i] != 0) s += mWeight[i];
      mSum = (s < 0) ? 0 : ((s > MAXV) ? MAXV : s);
      for (int i = 0; i < N; i++) neuronStep(i, curVal[i]);
    end
    if (we && wa < N) mWeight[wa] = wd;
  endfunction

  task automatic checkAll();
    int expL1;
    expL1 = 0;
    for (int i = 0; i < N; i++) if (mSpike[i] != 0) expL1 |= (1 << i);
    checkOutput("l1_spikes", int'(l1_spikes), expL1);
    checkOutput("sum_out",   int'(sum_out),   mSum);
    checkOutput("spike_out", int'(spike_out), mSpike[N]);
    checkOutput("state_out", int'(state_out), mState[N]);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit we, input int wa, input int wd);
    rst       = r;
    ena       = e;
    w_wr_en   = we;
    w_wr_addr = AW'(wa);
    w_wr_data = WW'(wd);
    for (int i = 0; i < N; i++) current[i*W +: W] = W'(curVal[i]);
    @(posedge clk);
    modelEdge(r, e, we, wa, wd);
    #1;
    checkAll();
  endtask

  task automatic setAll(input int v);
    for (int i = 0; i < N; i++) curVal[i] = v;
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    setAll(0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    checkOutput("reset_state", int'(state_out), 0);

    // Single neuron rise, then saturation.
    curVal[0] = 100;
    run(4);
    curVal[0] = 255;
    run(4);
    checkOutput("sat_spike", int'(l1_spikes[0]), 1);

    // Unit weights with all inputs saturated: output converges at 32 without spiking.
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    setAll(255);
    run(20);
    checkOutput("unit_sum", int'(sum_out), 8);
    checkOutput("unit_conv", int'(state_out), 32);

    // Weights 7 written while frozen.
    for (int i = 0; i < N; i++) applyStimulus(1'b0, 1'b0, 1'b1, i, 7);
    run(8);
    checkOutput("w7_sum", int'(sum_out), 56);

    // Weights -8 clamp the sum to zero.
    for (int i = 0; i < N; i++) applyStimulus(1'b0, 1'b1, 1'b1, i, -8);
    run(4);
    checkOutput("neg_clamp", int'(sum_out), 0);

    // Freeze with varying inputs.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) curVal[i] = $urandom_range(0, 255);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    end

    // Reset with coincident write: write must be discarded.
    applyStimulus(1'b1, 1'b1, 1'b1, 0, 7);
    checkOutput("rst_sum", int'(sum_out), 0);
    setAll(255);
    run(4);
    checkOutput("rst_unit_sum", int'(sum_out), 8);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       curVal[i] = 0;
          1:       curVal[i] = 255;
          default: curVal[i] = $urandom_range(0, 255);
        endcase
      end
      applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
                    ($urandom_range(0, 99) < 25), $urandom_range(0, N - 1),
                    int'($urandom_range(0, 15)) - 8);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
